mod_n_cnt: RTL



---
 rtl/mod_n_cnt_pkg.sv | 18 +
 rtl/mod_n_digit.sv | 51 +++++
 rtl/mod_n_cnt.sv | 82 ++++++++
 3 files changed

// File: rtl/mod_n_cnt_pkg.sv
// Shared limits, digit-width helper and direction encoding for the mod-N counter family.
package mod_n_cnt_pkg;

    localparam int MOD_MIN        = 2;
    localparam int MOD_MAX        = 256;
    localparam int NUM_DIGITS_MIN = 1;
    localparam int NUM_DIGITS_MAX = 8;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic int digit_width(input int modulus);
        return $clog2(modulus);
    endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One modulo-MOD digit: clear > load (clamped to MOD-1) > step; value updates one cycle after the edge.
// at_term is combinational: MOD-1 when counting up, 0 when counting down.
module mod_n_digit
    import mod_n_cnt_pkg::*;
#(
    parameter  int MOD = 10,
    localparam int DW  = digit_width(MOD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          step,
    input  dir_e          dir,
    output logic [DW-1:0] val,
    output logic          at_term
);

    localparam logic [DW-1:0] DIG_MAX = DW'(MOD - 1);

    logic [DW-1:0] val_q;
    logic [DW-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = '0;
        end else if (load) begin
            val_d = (load_val > DIG_MAX) ? DIG_MAX : load_val;
        end else if (step) begin
            if (dir == DIR_UP) begin
                val_d = (val_q == DIG_MAX) ? '0 : val_q + 1'b1;
            end else begin
                val_d = (val_q == '0) ? DIG_MAX : val_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val     = val_q;
    assign at_term = (dir == DIR_UP) ? (val_q == DIG_MAX) : (val_q == '0);

endmodule

// File: rtl/mod_n_cnt.sv
// Cascaded modulo-MOD up/down counter; cnt changes one cycle after the edge, tc is combinational, wrap is a registered pulse.
// No backpressure (en gates stepping). MOD_N_CNT_SAT_EN selects saturation at terminal instead of rollover.
module mod_n_cnt
    import mod_n_cnt_pkg::*;
#(
    parameter  int MOD        = 10,
    parameter  int NUM_DIGITS = 2,
    localparam int DW         = digit_width(MOD)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     up_dn,
    input  logic                     clr,
    input  logic                     load,
    input  logic [NUM_DIGITS*DW-1:0] load_val,
    output logic [NUM_DIGITS*DW-1:0] cnt,
    output logic                     tc,
    output logic                     wrap
);

    dir_e                  dir;
    logic [NUM_DIGITS-1:0] term;
    logic [NUM_DIGITS-1:0] step;
    logic                  all_term;
    logic                  step_en;
    logic                  wrap_q;
    logic                  wrap_d;

    assign dir      = dir_e'(up_dn);
    assign all_term = &term;
    assign tc       = en & all_term;

`ifdef MOD_N_CNT_SAT_EN
    // At full terminal the whole counter holds rather than rolling over.
    assign step_en = en & ~all_term;
`else
    assign step_en = en;
`endif

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_first
            assign step[k] = step_en;
        end else begin : g_chain
            assign step[k] = step[k-1] & term[k-1];
        end

        mod_n_digit #(
            .MOD (MOD)
        ) u_digit (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .load     (load),
            .load_val (load_val[k*DW +: DW]),
            .step     (step[k]),
            .dir      (dir),
            .val      (cnt[k*DW +: DW]),
            .at_term  (term[k])
        );
    end

    always_comb begin
        wrap_d = 1'b0;
`ifndef MOD_N_CNT_SAT_EN
        if (!clr && !load) begin
            wrap_d = tc;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule
